// File: rtl/exec_operand_stage.sv
// exec_operand_stage
//
// Operand-select and stage-3 pipeline register for the execute stage.
// Picks operands A and B from the forwarding sources (stage-3 ALU result,
// stage-4 writeback data, or register-file data), detects a load-use hazard
// against the load sitting in stage 3, and inserts a single-cycle bubble
// while holding PC/IF/ID through Stall.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   InValid, RegA2, RegB2         stage-2 valid and register-file read data
//   Rs2, Rt2, ALUOp2              stage-2 source indices and op class
//   HAs2d3/HAs2d4/HAs2t4          operand-A forwarding flags
//   HBt2d3/HBt2d4/HBt2t4          operand-B forwarding flags
//   ALUOut3, WBData4              forwarding data from stages 3 and 4
//   ALUOp3, Rt3                   stage-3 op class and load destination
//   Flush                         discard the stage-2 instruction
//   OpA3, OpB3, OutValid,         registered stage-3 operands, valid, op class
//   ALUOp3Out
//   Stall                         combinational hold request to PC/IF/ID
//   StallCount                    saturating count of load-use stall cycles
//
// Configuration
//   HAZ_ZERO_GUARD_EN  when defined, forwarding and load-use detection ignore
//                      register index 0.

module exec_operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        InValid,
    input  logic [31:0] RegA2,
    input  logic [31:0] RegB2,
    input  logic [4:0]  Rs2,
    input  logic [4:0]  Rt2,
    input  logic [1:0]  ALUOp2,
    input  logic        HAs2d3,
    input  logic        HAs2d4,
    input  logic        HAs2t4,
    input  logic        HBt2d3,
    input  logic        HBt2d4,
    input  logic        HBt2t4,
    input  logic [31:0] ALUOut3,
    input  logic [31:0] WBData4,
    input  logic [1:0]  ALUOp3,
    input  logic [4:0]  Rt3,
    input  logic        Flush,
    output logic [31:0] OpA3,
    output logic [31:0] OpB3,
    output logic        OutValid,
    output logic [1:0]  ALUOp3Out,
    output logic        Stall,
    output logic [15:0] StallCount
);

    localparam logic [1:0] OpLoad   = 2'b00;
    localparam logic [1:0] OpAlu    = 2'b10;
    localparam logic [1:0] OpBubble = 2'b11;

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    state_e      state_q, state_d;
    logic [31:0] op_a3_q, op_a3_d;
    logic [31:0] op_b3_q, op_b3_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  alu_op3_q, alu_op3_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic        a_guard, b_guard, lu_guard;
    logic        fwd_a_d3, fwd_a_wb, fwd_b_d3, fwd_b_wb;
    logic [31:0] sel_a, sel_b;
    logic        load_use;
    logic        stall;

`ifdef HAZ_ZERO_GUARD_EN
    // Register 0 is hardwired; a "hazard" on it is never real.
    assign a_guard  = (Rs2 != 5'd0);
    assign b_guard  = (Rt2 != 5'd0);
    assign lu_guard = (Rt3 != 5'd0);
`else
    assign a_guard  = 1'b1;
    assign b_guard  = 1'b1;
    assign lu_guard = 1'b1;
`endif

    // Forwarding is applied regardless of InValid; validity rides on OutValid.
    always_comb begin
        fwd_a_d3 = a_guard & HAs2d3;
        fwd_a_wb = a_guard & (HAs2d4 | HAs2t4);
        fwd_b_d3 = b_guard & HBt2d3;
        fwd_b_wb = b_guard & (HBt2d4 | HBt2t4);

        // Stage-3 result is the youngest, so it wins over stage 4.
        if (fwd_a_d3)      sel_a = ALUOut3;
        else if (fwd_a_wb) sel_a = WBData4;
        else               sel_a = RegA2;

        if (fwd_b_d3)      sel_b = ALUOut3;
        else if (fwd_b_wb) sel_b = WBData4;
        else               sel_b = RegB2;
    end

    // Only ALU ops read Rt as a source; a load in stage 2 uses Rt as its dest.
    assign load_use = InValid && (ALUOp3 == OpLoad) && lu_guard &&
                      ((Rt3 == Rs2) || ((ALUOp2 == OpAlu) && (Rt3 == Rt2)));

    // Masked in StStall so each instruction stalls at most once; gated by rst
    // so the hold request drops while the block is being reset.
    assign stall = !rst && (state_q == StIdle) && load_use && !Flush;

    always_comb begin
        state_d       = StIdle;
        op_a3_d       = op_a3_q;
        op_b3_d       = op_b3_q;
        out_valid_d   = InValid;
        alu_op3_d     = ALUOp2;
        stall_count_d = stall_count_q;

        if (Flush) begin
            out_valid_d = 1'b0;
            alu_op3_d   = OpBubble;
        end else if (stall) begin
            state_d     = StStall;
            out_valid_d = 1'b0;
            alu_op3_d   = OpBubble;
        end else begin
            op_a3_d = sel_a;
            op_b3_d = sel_b;
        end

        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            op_a3_q       <= 32'd0;
            op_b3_q       <= 32'd0;
            out_valid_q   <= 1'b0;
            alu_op3_q     <= OpBubble;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            op_a3_q       <= op_a3_d;
            op_b3_q       <= op_b3_d;
            out_valid_q   <= out_valid_d;
            alu_op3_q     <= alu_op3_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign OpA3       = op_a3_q;
    assign OpB3       = op_b3_q;
    assign OutValid   = out_valid_q;
    assign ALUOp3Out  = alu_op3_q;
    assign Stall      = stall;
    assign StallCount = stall_count_q;

endmodule

// File: doc/exec_operand_stage.md
EXEC_OPERAND_STAGE -- requirements
Module: exec_operand_stage

Interface
REQ-001 The block SHALL have these ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 The block SHALL have these stage-2 inputs: InValid  in  1  stage-2 instruction valid; RegA2, RegB2  in  32 each  register-file read data; Rs2, Rt2  in  5 each  source indices; ALUOp2  in  2  stage-2 op class (00 load, 10 ALU).
REQ-003 The block SHALL have these hazard flag inputs: HAs2d3, HAs2d4, HAs2t4, HBt2d3, HBt2d4, HBt2t4  in  1 each.
REQ-004 The block SHALL have these forwarding and load-use sources: ALUOut3  in  32  stage-3 ALU result; WBData4  in  32  stage-4 writeback data; ALUOp3  in  2  stage-3 op class; Rt3  in  5  stage-3 load destination.
REQ-005 The block SHALL have these inputs and outputs: Flush  in  1  discard stage-2 instruction; OpA3, OpB3  out  32 each  registered operands to stage 3; OutValid  out  1  registered valid; ALUOp3Out  out  2  registered op class; Stall  out  1  combinational hold request to PC/IF/ID; StallCount  out  16  load-use stall counter.

Function
REQ-006 The operand A select SHALL be ALUOut3 if HAs2d3, else WBData4 if HAs2d4 or HAs2t4, else RegA2; the d3 flag SHALL win over the d4/t4 flags.
REQ-007 The operand B select SHALL be ALUOut3 if HBt2d3, else WBData4 if HBt2d4 or HBt2t4, else RegB2.
REQ-008 The load-use condition SHALL be: InValid=1 and ALUOp3==00 and (Rt3==Rs2 or (ALUOp2==10 and Rt3==Rt2)).
REQ-009 The FSM SHALL have two states. IDLE -> STALL when load-use is true and Flush=0; STALL -> IDLE unconditionally after 1 cycle.
REQ-010 Stall SHALL equal 1 only in IDLE with load-use true and Flush=0; detection SHALL be masked in STALL, so a stall lasts at most 1 cycle per instruction.
REQ-011 On a rising edge with Stall=1, the block SHALL insert a bubble: OutValid<=0 and ALUOp3Out<=11; OpA3 and OpB3 SHALL hold their values.
REQ-012 On a rising edge with Flush=1, the block SHALL set OutValid<=0 and ALUOp3Out<=11 and SHALL set the FSM to IDLE; Flush SHALL take priority over Stall and over load.
REQ-013 Otherwise, each rising edge SHALL load OpA3 and OpB3 from the REQ-006/007 selects, OutValid<=InValid and ALUOp3Out<=ALUOp2; latency is 1 cycle.
REQ-014 StallCount SHALL increment by 1 on each edge where Stall=1 and SHALL saturate at 16'hFFFF (no wrap).
REQ-015 Forwarding flags SHALL be honoured regardless of InValid; only OutValid carries validity.

Reset
REQ-016 While rst=1, asynchronously: OpA3=0, OpB3=0, OutValid=0, ALUOp3Out=11, StallCount=0, FSM=IDLE; Stall SHALL then equal 0.
REQ-017 An rst asserted mid-stall SHALL abort the stall; after release the block SHALL re-evaluate load-use from IDLE.

Configuration
REQ-018 The macro HAZ_ZERO_GUARD_EN SHALL control zero-register forwarding suppression.
REQ-019 With HAZ_ZERO_GUARD_EN defined, the A-side flags SHALL be ignored when Rs2==0, the B-side flags SHALL be ignored when Rt2==0, and load-use SHALL be false when Rt3==0.
REQ-020 With HAZ_ZERO_GUARD_EN undefined, the flags and load-use SHALL be used exactly as given, with no index-0 check.

Verification
REQ-021 Priority test: set RegA2=1, ALUOut3=2, WBData4=3, HAs2d3=1, HAs2d4=1 -> after 1 edge, OpA3=2 and OutValid=InValid.
REQ-022 Load-use test: stage 3 is a load with Rt3=5, stage 2 is an ALU op with Rs2=5, InValid=1 -> Stall=1 for exactly 1 cycle, OutValid=0 in the bubble, StallCount=1, then the next edge captures WBData4 via HAs2t4.
REQ-023 Flush test: assert Flush and load-use in the same cycle -> Stall=0, OutValid=0, FSM=IDLE, StallCount unchanged.
REQ-024 Saturation test: preload 65534 stall cycles, then apply 3 more load-use events -> StallCount=16'hFFFF.
REQ-025 Zero-register test: Rs2=0, HAs2d3=1, ALUOut3=7, RegA2=0 -> OpA3=0 with HAZ_ZERO_GUARD_EN defined, OpA3=7 without it.
REQ-026 Reset test: assert rst asynchronously during STALL -> all outputs go to their reset values immediately (before the next edge), and Stall=0.
